// File: rtl/noc_out_port_arb.sv
// Per-output-port wormhole scheduler. Requesters are picked round-robin,
// and the winner keeps the output until its tlast beat has been accepted.
// A beat counter flags packets that run to MAX_BEATS beats without tlast.
module noc_out_port_arb #(
  parameter int N_REQ     = 5,
  parameter int IDX_W     = $clog2(N_REQ),
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_vld_i,
  input  logic [N_REQ-1:0] req_last_i,
  input  logic             dn_rdy_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic [N_REQ-1:0] up_rdy_o,
  output logic             dn_vld_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] beat_cnt_o,
  output logic             ovf_err_o
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t           state_reg;
  logic [IDX_W-1:0] rr_ptr_reg;
  logic [IDX_W-1:0] lock_idx_reg;
  logic [CNT_W-1:0] beat_cnt_reg;
  logic             ovf_err_reg;

  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] cand;
  logic             any_vld;
  logic [IDX_W-1:0] cur_idx;
  logic             gnt_en;
  logic [N_REQ-1:0] onehot;
  logic             hs;
  logic             cur_last;

  // Index after i, wrapping N_REQ-1 back to 0.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(N_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  // Cyclic search from rr_ptr; walking downwards lets the nearest valid
  // requester overwrite any farther one.
  always_comb begin
    sel     = '0;
    cand    = '0;
    any_vld = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (int'(rr_ptr_reg) + k >= N_REQ)
        cand = IDX_W'(int'(rr_ptr_reg) + k - N_REQ);
      else
        cand = IDX_W'(int'(rr_ptr_reg) + k);
      if (req_vld_i[cand]) begin
        sel     = cand;
        any_vld = 1'b1;
      end
    end
  end

  // In LOCK the grant is frozen on the packet owner; in IDLE it follows the search.
  assign cur_idx = (state_reg == LOCK) ? lock_idx_reg : sel;
  assign gnt_en  = !rst && ((state_reg == LOCK) || any_vld);

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_gnt
    assign onehot[gi] = (cur_idx == IDX_W'(gi));
    assign gnt_o[gi]  = gnt_en && onehot[gi];
  end

  assign gnt_idx_o  = cur_idx;
  assign up_rdy_o   = gnt_o & {N_REQ{dn_rdy_i}};
  assign dn_vld_o   = |(gnt_o & req_vld_i);
  assign hs         = dn_vld_o & dn_rdy_i;
  assign cur_last   = req_last_i[cur_idx];
  assign busy_o     = !rst && (state_reg == LOCK);
  assign beat_cnt_o = beat_cnt_reg;
  assign ovf_err_o  = ovf_err_reg;

  // Packet-level scheduling: lock on first beat or stall, release after tlast.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      lock_idx_reg <= '0;
      beat_cnt_reg <= '0;
      ovf_err_reg  <= 1'b0;
    end else begin
      ovf_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (hs && cur_last) begin
            rr_ptr_reg <= next_idx(sel);
          end else if (any_vld) begin
            state_reg    <= LOCK;
            lock_idx_reg <= sel;
            beat_cnt_reg <= hs ? CNT_W'(1) : '0;
          end
        end
        LOCK: begin
          if (hs) begin
            if (cur_last) begin
              state_reg    <= IDLE;
              rr_ptr_reg   <= next_idx(lock_idx_reg);
              beat_cnt_reg <= '0;
            end else if (beat_cnt_reg != CNT_W'(MAX_BEATS)) begin
              beat_cnt_reg <= beat_cnt_reg + 1'b1;
              if (beat_cnt_reg == CNT_W'(MAX_BEATS - 1))
                ovf_err_reg <= 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_out_port_arb.sv
// Directed bench for noc_out_port_arb: reset, round robin, wormhole hold,
// stall stability, overflow flagging and mid-packet reset.
module tb_noc_out_port_arb;

  localparam int N_REQ = 5;
  localparam int IDX_W = 3;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_REQ-1:0] req_vld_i;
  logic [N_REQ-1:0] req_last_i;
  logic             dn_rdy_i;
  logic [N_REQ-1:0] gnt_o;
  logic [IDX_W-1:0] gnt_idx_o;
  logic [N_REQ-1:0] up_rdy_o;
  logic             dn_vld_o;
  logic             busy_o;
  logic [CNT_W-1:0] beat_cnt_o;
  logic             ovf_err_o;

  int checks   = 0;
  int failures = 0;

  noc_out_port_arb #(.N_REQ(5), .MAX_BEATS(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_vld_i  (req_vld_i),
    .req_last_i (req_last_i),
    .dn_rdy_i   (dn_rdy_i),
    .gnt_o      (gnt_o),
    .gnt_idx_o  (gnt_idx_o),
    .up_rdy_o   (up_rdy_o),
    .dn_vld_o   (dn_vld_o),
    .busy_o     (busy_o),
    .beat_cnt_o (beat_cnt_o),
    .ovf_err_o  (ovf_err_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_vld_i = 5'b11111; req_last_i = 5'b11111; dn_rdy_i = 1'b1;
    #1;
    checks++; if (gnt_o !== 5'b0) begin failures++; $display("FAIL rst_gnt got=%b exp=%b", gnt_o, 5'b0); end
    checks++; if (up_rdy_o !== 5'b0) begin failures++; $display("FAIL rst_up_rdy got=%b exp=%b", up_rdy_o, 5'b0); end
    checks++; if (dn_vld_o !== 1'b0) begin failures++; $display("FAIL rst_dn_vld got=%b exp=0", dn_vld_o); end
    tick; tick;
    rst = 1'b0; req_vld_i = 5'b0; req_last_i = 5'b0;
    #1;
    $display("test_reset: gnt=%b dn_vld=%b busy=%b cnt=%0d ovf=%b", gnt_o, dn_vld_o, busy_o, beat_cnt_o, ovf_err_o);
    checks++; if (gnt_o !== 5'b0) begin failures++; $display("FAIL idle_gnt got=%b exp=%b", gnt_o, 5'b0); end
    checks++; if (dn_vld_o !== 1'b0) begin failures++; $display("FAIL idle_dn_vld got=%b exp=0", dn_vld_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy_o); end
    checks++; if (beat_cnt_o !== 5'd0) begin failures++; $display("FAIL idle_cnt got=%0d exp=0", beat_cnt_o); end
    checks++; if (ovf_err_o !== 1'b0) begin failures++; $display("FAIL idle_ovf got=%b exp=0", ovf_err_o); end
    tick;
    checks++; if (gnt_o !== 5'b0) begin failures++; $display("FAIL idle_gnt2 got=%b exp=%b", gnt_o, 5'b0); end
  endtask

  // Single-beat packets from everyone: the pointer advances every cycle.
  task automatic test_round_robin;
    logic [IDX_W-1:0] exp_idx [6];
    exp_idx = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    req_vld_i = 5'b11111; req_last_i = 5'b11111; dn_rdy_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      $display("test_round_robin[%0d]: idx=%0d gnt=%b dn_vld=%b busy=%b", c, gnt_idx_o, gnt_o, dn_vld_o, busy_o);
      checks++; if (gnt_idx_o !== exp_idx[c]) begin failures++; $display("FAIL rr_idx[%0d] got=%0d exp=%0d", c, gnt_idx_o, exp_idx[c]); end
      checks++; if (gnt_o !== (5'b1 << exp_idx[c])) begin failures++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", c, gnt_o, 5'b1 << exp_idx[c]); end
      checks++; if (dn_vld_o !== 1'b1 || busy_o !== 1'b0) begin failures++; $display("FAIL rr_hs[%0d] got dn_vld=%b busy=%b exp 1/0", c, dn_vld_o, busy_o); end
      tick;
    end
    req_vld_i = 5'b0; req_last_i = 5'b0;
  endtask

  // Req 1 owns the port for 4 beats though req 3 waits; pointer starts at 1.
  task automatic test_wormhole;
    logic [CNT_W-1:0] exp_cnt [4];
    exp_cnt = '{5'd0, 5'd1, 5'd2, 5'd3};
    dn_rdy_i = 1'b1; req_vld_i = 5'b01010;
    for (int b = 1; b <= 4; b++) begin
      req_last_i = (b == 4) ? 5'b00010 : 5'b00000;
      #1;
      $display("test_wormhole beat %0d: gnt=%b cnt=%0d busy=%b", b, gnt_o, beat_cnt_o, busy_o);
      checks++; if (gnt_o !== 5'b00010) begin failures++; $display("FAIL worm_gnt[%0d] got=%b exp=%b", b, gnt_o, 5'b00010); end
      checks++; if (beat_cnt_o !== exp_cnt[b-1]) begin failures++; $display("FAIL worm_cnt[%0d] got=%0d exp=%0d", b, beat_cnt_o, exp_cnt[b-1]); end
      checks++; if (up_rdy_o !== 5'b00010) begin failures++; $display("FAIL worm_up_rdy[%0d] got=%b exp=%b", b, up_rdy_o, 5'b00010); end
      tick;
    end
    req_vld_i = 5'b01000; req_last_i = 5'b01000;
    #1;
    $display("test_wormhole after: gnt=%b cnt=%0d busy=%b", gnt_o, beat_cnt_o, busy_o);
    checks++; if (gnt_o !== 5'b01000) begin failures++; $display("FAIL worm_next_gnt got=%b exp=%b", gnt_o, 5'b01000); end
    checks++; if (beat_cnt_o !== 5'd0) begin failures++; $display("FAIL worm_end_cnt got=%0d exp=0", beat_cnt_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL worm_end_busy got=%b exp=0", busy_o); end
    tick;  // req 3 single-beat packet, pointer -> 4
    req_vld_i = 5'b0; req_last_i = 5'b0;
  endtask

  // Stalled grant on req 2 must not move when req 0 appears.
  task automatic test_stall;
    req_vld_i = 5'b00100; req_last_i = 5'b00000; dn_rdy_i = 1'b0;
    #1;
    $display("test_stall c0: gnt=%b dn_vld=%b up_rdy=%b busy=%b", gnt_o, dn_vld_o, up_rdy_o, busy_o);
    checks++; if (gnt_o !== 5'b00100) begin failures++; $display("FAIL stall_gnt0 got=%b exp=%b", gnt_o, 5'b00100); end
    checks++; if (up_rdy_o !== 5'b0 || dn_vld_o !== 1'b1) begin failures++; $display("FAIL stall_hs0 got up_rdy=%b dn_vld=%b exp 00000/1", up_rdy_o, dn_vld_o); end
    tick;
    req_vld_i = 5'b00101;
    #1;
    $display("test_stall c1: gnt=%b busy=%b cnt=%0d", gnt_o, busy_o, beat_cnt_o);
    checks++; if (gnt_o !== 5'b00100) begin failures++; $display("FAIL stall_gnt1 got=%b exp=%b", gnt_o, 5'b00100); end
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL stall_busy got=%b exp=1", busy_o); end
    checks++; if (beat_cnt_o !== 5'd0) begin failures++; $display("FAIL stall_cnt got=%0d exp=0", beat_cnt_o); end
    tick;
    checks++; if (gnt_o !== 5'b00100) begin failures++; $display("FAIL stall_gnt2 got=%b exp=%b", gnt_o, 5'b00100); end
    dn_rdy_i = 1'b1; req_last_i = 5'b00100;
    tick;  // req 2 last beat, pointer -> 3
    req_vld_i = 5'b00001; req_last_i = 5'b00001;
    #1;
    $display("test_stall after: gnt=%b busy=%b", gnt_o, busy_o);
    checks++; if (gnt_o !== 5'b00001) begin failures++; $display("FAIL stall_next_gnt got=%b exp=%b", gnt_o, 5'b00001); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL stall_next_busy got=%b exp=0", busy_o); end
    tick;  // req 0 single beat, pointer -> 1
    req_vld_i = 5'b0; req_last_i = 5'b0;
  endtask

  // 20-beat packet from req 4: one overflow pulse after beat 16, counter saturates.
  task automatic test_overflow;
    int pulses = 0;
    logic [CNT_W-1:0] exp_cnt;
    req_vld_i = 5'b10000; dn_rdy_i = 1'b1;
    for (int b = 1; b <= 20; b++) begin
      req_last_i = (b == 20) ? 5'b10000 : 5'b00000;
      #1;
      checks++; if (gnt_o !== 5'b10000) begin failures++; $display("FAIL ovf_gnt[%0d] got=%b exp=%b", b, gnt_o, 5'b10000); end
      tick;
      exp_cnt = (b == 20) ? 5'd0 : ((b > 16) ? 5'd16 : CNT_W'(b));
      $display("test_overflow beat %0d: cnt=%0d ovf=%b busy=%b", b, beat_cnt_o, ovf_err_o, busy_o);
      checks++; if (ovf_err_o !== (b == 16)) begin failures++; $display("FAIL ovf_pulse[%0d] got=%b exp=%b", b, ovf_err_o, b == 16); end
      checks++; if (beat_cnt_o !== exp_cnt) begin failures++; $display("FAIL ovf_cnt[%0d] got=%0d exp=%0d", b, beat_cnt_o, exp_cnt); end
      if (ovf_err_o === 1'b1) pulses++;
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL ovf_pulse_count got=%0d exp=1", pulses); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL ovf_end_busy got=%b exp=0", busy_o); end
    req_vld_i = 5'b11111; req_last_i = 5'b11111;
    #1;
    $display("test_overflow wrap: idx=%0d", gnt_idx_o);
    checks++; if (gnt_idx_o !== 3'd0) begin failures++; $display("FAIL ovf_wrap_idx got=%0d exp=0", gnt_idx_o); end
    dn_rdy_i = 1'b0; req_vld_i = 5'b0; req_last_i = 5'b0;
    #1;
  endtask

  // Reset after beat 2 of a 5-beat packet from req 1 drops the lock.
  task automatic test_mid_reset;
    req_vld_i = 5'b00010; req_last_i = 5'b0; dn_rdy_i = 1'b1;
    tick; tick;
    checks++; if (busy_o !== 1'b1 || beat_cnt_o !== 5'd2) begin failures++; $display("FAIL mrst_pre got busy=%b cnt=%0d exp 1/2", busy_o, beat_cnt_o); end
    rst = 1'b1;
    #1;
    checks++; if (gnt_o !== 5'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL mrst_force got gnt=%b busy=%b exp 00000/0", gnt_o, busy_o); end
    tick;
    rst = 1'b0; req_vld_i = 5'b0;
    #1;
    $display("test_mid_reset: gnt=%b busy=%b cnt=%0d", gnt_o, busy_o, beat_cnt_o);
    checks++; if (gnt_o !== 5'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL mrst_idle got gnt=%b busy=%b exp 00000/0", gnt_o, busy_o); end
    checks++; if (beat_cnt_o !== 5'd0) begin failures++; $display("FAIL mrst_cnt got=%0d exp=0", beat_cnt_o); end
    req_vld_i = 5'b11111; req_last_i = 5'b0; dn_rdy_i = 1'b0;
    #1;
    checks++; if (gnt_idx_o !== 3'd0) begin failures++; $display("FAIL mrst_rr_ptr got=%0d exp=0", gnt_idx_o); end
    req_vld_i = 5'b01000; req_last_i = 5'b01000; dn_rdy_i = 1'b1;
    #1;
    $display("test_mid_reset new: gnt=%b dn_vld=%b busy=%b", gnt_o, dn_vld_o, busy_o);
    checks++; if (gnt_o !== 5'b01000 || dn_vld_o !== 1'b1) begin failures++; $display("FAIL mrst_new_gnt got gnt=%b dn_vld=%b exp 01000/1", gnt_o, dn_vld_o); end
    tick;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL mrst_new_busy got=%b exp=0", busy_o); end
    req_vld_i = 5'b0; req_last_i = 5'b0;
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_wormhole;
    test_stall;
    test_overflow;
    test_mid_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
